bcd_serial_subtractor: RTL and testbench
========================================

// Module: bcd_serial_subtractor
//
// PURPOSE
// Digit-serial multi-digit BCD subtractor: computes d = a - b - bin over DIGITS packed
// BCD digits, one digit per clock, least-significant digit first, with a 10s-complement
// borrow chain. It is the subtract-direction partner of the combinational BCD adder.
// It sits in the lab datapath wherever decimal counters and registers need a difference.
// It uses a start/busy/done handshake so that a controller FSM can sequence it.
//
// PARAMETERS
// DIGITS   4   number of BCD digits per operand (>=1); operand width is 4*DIGITS bits
//
// PORTS
// clk    in   1           rising-edge clock
// rst    in   1           synchronous, active-high reset
// start  in   1           request; sampled only in IDLE or DONE
// a      in   4*DIGITS    minuend, packed BCD, digit 0 = a[3:0]
// b      in   4*DIGITS    subtrahend, packed BCD
// bin    in   1           borrow in (subtracts one extra unit)
// busy   out  1           high while digits are being processed (RUN)
// done   out  1           one-cycle pulse when d/bout are valid
// d      out  4*DIGITS    difference, packed BCD; held until the next accepted start
// bout   out  1           borrow out: 1 when a < b+bin (d = 10^DIGITS + a - b - bin)
// err    out  1           present only with BCD_CHECK_EN (see CONFIGURATION)
//
// BEHAVIOUR
// - Reset: state=IDLE; busy=0, done=0, d=0, bout=0, err=0; the digit index and borrow clear.
// - FSM IDLE -> RUN -> DONE -> IDLE. DONE lasts exactly one cycle.
// - Accept: at clock edge E0 with start=1 in IDLE or DONE, latch a, b, and bin (as the
//   initial borrow); idx=0; go to RUN. Back-to-back operation from DONE is legal.
// - start is ignored while in RUN; the operands must be stable only at E0.
// - RUN, edge Ek (k=1..DIGITS) processes digit idx=k-1: t = a_i - b_i - borrow (signed 5b).
//   If t<0 then d_i = t+10 and borrow=1; else d_i = t and borrow=0. idx increments.
// - At E_DIGITS: write the final borrow to bout; go to DONE. After that edge busy=0 and done=1.
// - Latency: done is high in the cycle after edge E_DIGITS, i.e. DIGITS cycles after acceptance.
// - busy=1 exactly in the cycles after E0 .. E_(DIGITS-1).
// - d updates digit by digit during RUN. It is defined only while done=1 or later, and
//   stays stable until the next accept.
// - Input nibbles >9 (checking disabled): the same arithmetic is applied. The result is
//   deterministic but is not a valid BCD result.
// - Reset mid-RUN: the operation is aborted. The next cycle shows IDLE, busy=0, done=0, d=0, bout=0.
// - Simultaneous rst and start: rst wins.
//
// CONFIGURATION
// BCD_CHECK_EN defined:
// - The err port exists. At accept, err = 1 if any nibble of a or b is >9.
// - When err=1 the full DIGITS-cycle latency is still taken, then d is forced to 0 and
//   bout to 0 when done rises.
// - err is held until the next accept or reset.
// BCD_CHECK_EN undefined:
// - There is no err port and no checking logic; invalid nibbles follow the raw arithmetic
//   described in BEHAVIOUR.
//
// TESTING (DIGITS=4)
// - a=0042, b=0013, bin=0 -> d=0029, bout=0; done exactly 4 cycles after the start edge, one cycle wide.
// - a=0000, b=0001, bin=0 -> d=9999, bout=1 (borrow ripples through all digits).
// - a=1000, b=0999, bin=1 -> d=0000, bout=0; a=9999, b=9999, bin=1 -> d=9999, bout=1.
// - start re-pulsed while busy with a=0005 -> ignored, first result unchanged.
//   Start asserted during done -> new op accepted, busy the next cycle.
// - rst asserted during the 2nd RUN cycle -> next cycle busy=0, done=0, d=0000, bout=0.
//   No done pulse follows.
// - BCD_CHECK_EN: a=00A1, b=0001 -> err=1, d=0000, bout=0 at done; then a=0001 -> err=0.

Source files
------------

// File: rtl/bcd_serial_subtractor.sv
// bcd_serial_subtractor: digit-serial packed-BCD subtractor d = a - b - bin, LSD first, start/busy/done handshake.
// Optional input nibble checking and the err port are enabled by defining BCD_CHECK_EN.
module bcd_serial_subtractor #(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [4*DIGITS-1:0] a,
    input  logic [4*DIGITS-1:0] b,
    input  logic                bin,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] d,
    output logic                bout
`ifdef BCD_CHECK_EN
    ,
    output logic                err
`endif
);
    localparam int W  = 4 * DIGITS;
    localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state, state_n;
    logic [IW-1:0]   idx;
    logic [W-1:0]    a_r, b_r;
    logic            borrow, accept, last;
    logic [3:0]      ai, bi, dn;
    logic signed [5:0] t;

    always_comb begin
        accept  = start && state != RUN;
        last    = idx == IW'(DIGITS - 1);
        ai      = a_r[{idx, 2'b00} +: 4];
        bi      = b_r[{idx, 2'b00} +: 4];
        // 6 bits keep raw (non-BCD) nibble differences from overflowing the sign
        t       = $signed({2'b00, ai}) - $signed({2'b00, bi}) - $signed({5'b0, borrow});
        dn      = t[3:0] + (t[5] ? 4'd10 : 4'd0);
        state_n = state;
        if (accept)
            state_n = RUN;
        else if (state == RUN && last)
            state_n = DONE;
        else if (state == DONE)
            state_n = IDLE;
        busy    = state == RUN;
        done    = state == DONE;
    end

`ifdef BCD_CHECK_EN
    logic bad;
    always_comb begin
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++)
            bad = bad | (a[4*i +: 4] > 4'd9) | (b[4*i +: 4] > 4'd9);
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            idx    <= '0;
            borrow <= 1'b0;
            a_r    <= '0;
            b_r    <= '0;
            d      <= '0;
            bout   <= 1'b0;
`ifdef BCD_CHECK_EN
            err    <= 1'b0;
`endif
        end else begin
            state <= state_n;
            if (accept) begin
                a_r    <= a;
                b_r    <= b;
                borrow <= bin;
                idx    <= '0;
`ifdef BCD_CHECK_EN
                err    <= bad;
`endif
            end else if (state == RUN) begin
                d[{idx, 2'b00} +: 4] <= dn;
                borrow               <= t[5];
                idx                  <= idx + 1'b1;
                if (last)
                    bout <= t[5];
`ifdef BCD_CHECK_EN
                // flagged operands still take the full latency, then report zero
                if (last && err) begin
                    d    <= '0;
                    bout <= 1'b0;
                end
`endif
            end
        end
    end
endmodule

// File: tb/tb_bcd_serial_subtractor.sv
// tb_bcd_serial_subtractor: directed and randomized checks of bcd_serial_subtractor against an integer-arithmetic model.
// Define BCD_CHECK_EN to also exercise the err port.
module tb_bcd_serial_subtractor;
    localparam int DIGITS = 4;
    localparam int W = 4 * DIGITS;

    logic clk = 1'b0;
    logic rst, start, bin, busy, done, bout;
    logic [W-1:0] a, b, d;
`ifdef BCD_CHECK_EN
    logic err;
`endif
    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    bcd_serial_subtractor #(.DIGITS(DIGITS)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
        .busy(busy), .done(done), .d(d), .bout(bout)
`ifdef BCD_CHECK_EN
        , .err(err)
`endif
    );

    function automatic logic [W-1:0] to_bcd(input int v);
        logic [W-1:0] r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    task automatic launch(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi);
        a = x; b = y; bin = bi; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int cyc, output bit busy_ok);
        cyc = 0;
        busy_ok = 1'b1;
        do begin
            @(posedge clk); #1;
            cyc++;
            if (!done && !busy) busy_ok = 1'b0;
        end while (!done && cyc < 20);
    endtask

    task automatic check_op(input string name, input logic [W-1:0] x, input logic [W-1:0] y,
                            input logic bi, input logic [W-1:0] exp_d, input logic exp_bo);
        int cyc;
        bit bok;
        launch(x, y, bi);
        n_cmp++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL %s busy after accept: got %b expected 1", name, busy); end
        wait_done(cyc, bok);
        n_cmp++;
        if (cyc !== DIGITS) begin n_fail++; $display("FAIL %s latency: got %0d expected %0d", name, cyc, DIGITS); end
        n_cmp++;
        if (!bok) begin n_fail++; $display("FAIL %s busy dropped early: got 0 expected 1", name); end
        n_cmp++;
        if (d !== exp_d) begin n_fail++; $display("FAIL %s d: got %h expected %h", name, d, exp_d); end
        n_cmp++;
        if (bout !== exp_bo) begin n_fail++; $display("FAIL %s bout: got %b expected %b", name, bout, exp_bo); end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset busy: got %b expected 0", busy); end
        n_cmp++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL reset done: got %b expected 0", done); end
        n_cmp++;
        if (d !== '0) begin n_fail++; $display("FAIL reset d: got %h expected 0000", d); end
        n_cmp++;
        if (bout !== 1'b0) begin n_fail++; $display("FAIL reset bout: got %b expected 0", bout); end
        rst = 1'b0;
    endtask

    task automatic test_rst_wins();
        rst = 1'b1; start = 1'b1; a = 16'h0042; b = 16'h0013;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        n_cmp++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_wins busy: got %b expected 0", busy); end
    endtask

    task automatic test_directed();
        check_op("d0042", 16'h0042, 16'h0013, 1'b0, 16'h0029, 1'b0);
        @(posedge clk); #1;
        n_cmp++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL done_width: got %b expected 0", done); end
        check_op("ripple", 16'h0000, 16'h0001, 1'b0, 16'h9999, 1'b1);
        @(posedge clk); #1;
        check_op("d1000", 16'h1000, 16'h0999, 1'b1, 16'h0000, 1'b0);
        @(posedge clk); #1;
        check_op("d9999", 16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1);
        @(posedge clk); #1;
    endtask

    task automatic test_ignore_start();
        int cyc;
        bit bok;
        launch(16'h0042, 16'h0013, 1'b0);
        a = 16'h0005; b = 16'h0000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(cyc, bok);
        n_cmp++;
        if (d !== 16'h0029) begin n_fail++; $display("FAIL ignore_start d: got %h expected 0029", d); end
        @(posedge clk); #1;
        n_cmp++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL ignore_start extra op busy: got %b expected 0", busy); end
    endtask

    task automatic test_back_to_back();
        check_op("b2b_first", 16'h0100, 16'h0001, 1'b0, 16'h0099, 1'b0);
        check_op("b2b_second", 16'h0003, 16'h0007, 1'b0, 16'h9996, 1'b1);
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        bit seen = 1'b0;
        check_op("pre_abort", 16'h0777, 16'h0111, 1'b0, 16'h0666, 1'b0);
        launch(16'h0042, 16'h0013, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_cmp++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL abort busy: got %b expected 0", busy); end
        n_cmp++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL abort done: got %b expected 0", done); end
        n_cmp++;
        if (d !== '0) begin n_fail++; $display("FAIL abort d: got %h expected 0000", d); end
        n_cmp++;
        if (bout !== 1'b0) begin n_fail++; $display("FAIL abort bout: got %b expected 0", bout); end
        repeat (8) begin
            @(posedge clk); #1;
            if (done) seen = 1'b1;
        end
        n_cmp++;
        if (seen) begin n_fail++; $display("FAIL abort stray done: got 1 expected 0"); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            int va, vb, bi, diff;
            va = int'($urandom_range(0, 9999));
            vb = int'($urandom_range(0, 9999));
            bi = int'($urandom_range(0, 1));
            if (i % 6 == 0) vb = va;
            diff = va - vb - bi;
            check_op($sformatf("rand%0d", i), to_bcd(va), to_bcd(vb), bi[0],
                     to_bcd(diff < 0 ? diff + 10000 : diff), diff < 0);
            if ($urandom_range(0, 1) == 1) begin
                @(posedge clk); #1;
            end
        end
        @(posedge clk); #1;
    endtask

`ifdef BCD_CHECK_EN
    task automatic test_err();
        check_op("err_bad", 16'h00A1, 16'h0001, 1'b0, 16'h0000, 1'b0);
        n_cmp++;
        if (err !== 1'b1) begin n_fail++; $display("FAIL err_bad err: got %b expected 1", err); end
        @(posedge clk); #1;
        n_cmp++;
        if (err !== 1'b1) begin n_fail++; $display("FAIL err_hold err: got %b expected 1", err); end
        check_op("err_good", 16'h0005, 16'h0001, 1'b0, 16'h0004, 1'b0);
        n_cmp++;
        if (err !== 1'b0) begin n_fail++; $display("FAIL err_good err: got %b expected 0", err); end
        @(posedge clk); #1;
    endtask
`else
    task automatic test_raw_nibbles();
        check_op("raw_f", 16'h000F, 16'h0003, 1'b0, 16'h000C, 1'b0);
        @(posedge clk); #1;
        check_op("raw_a", 16'h0000, 16'h00A0, 1'b0, 16'h9900, 1'b1);
        @(posedge clk); #1;
    endtask
`endif

    initial begin
        test_reset();
        test_rst_wins();
        test_directed();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        test_random();
`ifdef BCD_CHECK_EN
        test_err();
`else
        test_raw_nibbles();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
